// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Per-frame lifecycle controller for the lane-detection accelerator. It
// generates a multi-cycle soft-reset pulse for the datapath. It tracks each
// frame through load, compute and done. It counts the pixels accepted into the
// input FIFO and detects completion from post-process. It also aborts a
// compute phase that runs too long. Status and sticky error flags feed the
// AXI register read mux.
//
// Ports
//   clk             in   clock, all logic on the rising edge
//   rst_n           in   synchronous active-low reset
//   soft_reset_req  in   one-cycle pulse from a write to the RESET register
//   first_pixel     in   marks the current fifo_wr_en as pixel 0 of a frame
//   fifo_wr_en      in   pixel accepted into the input FIFO
//   weight_we       in   weight memory write
//   done_in         in   post-process o_valid level (edge detected here)
//   internal_rst_n  out  registered active-low reset to the datapath
//   busy            out  high while loading or computing
//   frame_done      out  sticky, high in DONE
//   frame_count     out  completed frames, wraps
//   pixel_count     out  pixels accepted in the current frame
//   err_sequence    out  sticky protocol error
//   err_weight_busy out  sticky: weight write while busy
//   err_timeout     out  sticky: compute timeout
//
// Every output is a register loaded from the same next-state logic as the
// FSM, so each one reflects its triggering event exactly one cycle later.
// -----------------------------------------------------------------------------
module frame_sequencer #(
  parameter int NUM_PIXELS      = 131072,
  parameter int RESET_CYCLES    = 15,
  parameter int TIMEOUT_CYCLES  = 16777216,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              soft_reset_req,
  input  logic                              first_pixel,
  input  logic                              fifo_wr_en,
  input  logic                              weight_we,
  input  logic                              done_in,
  output logic                              internal_rst_n,
  output logic                              busy,
  output logic                              frame_done,
  output logic [FRAME_CNT_WIDTH-1:0]        frame_count,
  output logic [$clog2(NUM_PIXELS+1)-1:0]   pixel_count,
  output logic                              err_sequence,
  output logic                              err_weight_busy,
  output logic                              err_timeout
);

  localparam int PIX_W = $clog2(NUM_PIXELS + 1);
  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DONE
  } state_t;

  state_t                       state_reg, state_next;
  logic [RST_W-1:0]             rst_cnt_reg, rst_cnt_next;
  logic [TMO_W-1:0]             tmo_cnt_reg, tmo_cnt_next;
  logic                         done_in_d_reg;
  logic                         int_rst_n_reg, int_rst_n_next;
  logic                         busy_reg, busy_next;
  logic                         frame_done_reg, frame_done_next;
  logic [FRAME_CNT_WIDTH-1:0]   frame_count_reg, frame_count_next;
  logic [PIX_W-1:0]             pixel_count_reg, pixel_count_next;
  logic                         err_seq_reg, err_seq_next;
  logic                         err_wb_reg, err_wb_next;
  logic                         err_tmo_reg, err_tmo_next;
  logic                         done_rise;
  logic [PIX_W-1:0]             pixel_inc;

  assign done_rise = done_in & ~done_in_d_reg;
  assign pixel_inc = pixel_count_reg + PIX_W'(1);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_RESET;
      rst_cnt_reg     <= '0;
      tmo_cnt_reg     <= '0;
      done_in_d_reg   <= 1'b0;
      int_rst_n_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
      pixel_count_reg <= '0;
      err_seq_reg     <= 1'b0;
      err_wb_reg      <= 1'b0;
      err_tmo_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rst_cnt_reg     <= rst_cnt_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      done_in_d_reg   <= done_in;
      int_rst_n_reg   <= int_rst_n_next;
      busy_reg        <= busy_next;
      frame_done_reg  <= frame_done_next;
      frame_count_reg <= frame_count_next;
      pixel_count_reg <= pixel_count_next;
      err_seq_reg     <= err_seq_next;
      err_wb_reg      <= err_wb_next;
      err_tmo_reg     <= err_tmo_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    rst_cnt_next     = rst_cnt_reg;
    tmo_cnt_next     = tmo_cnt_reg;
    frame_done_next  = frame_done_reg;
    frame_count_next = frame_count_reg;
    pixel_count_next = pixel_count_reg;
    err_seq_next     = err_seq_reg;
    err_wb_next      = err_wb_reg;
    err_tmo_next     = err_tmo_reg;

    if (soft_reset_req && (state_reg != ST_RESET)) begin
      // A soft reset wins over anything else in the same cycle. frame_count
      // survives it, so software can keep a running total across aborts.
      state_next       = ST_RESET;
      rst_cnt_next     = '0;
      tmo_cnt_next     = '0;
      frame_done_next  = 1'b0;
      pixel_count_next = '0;
      err_seq_next     = 1'b0;
      err_wb_next      = 1'b0;
      err_tmo_next     = 1'b0;
    end else begin
      // The weight write still goes through. It is only flagged here.
      if (weight_we && ((state_reg == ST_LOAD) || (state_reg == ST_COMPUTE))) begin
        err_wb_next = 1'b1;
      end

      case (state_reg)
        ST_RESET: begin
          if (rst_cnt_reg == RST_LAST) begin
            state_next   = ST_IDLE;
            rst_cnt_next = '0;
          end else begin
            rst_cnt_next = rst_cnt_reg + RST_W'(1);
          end
        end

        ST_IDLE, ST_DONE: begin
          if (fifo_wr_en) begin
            if (first_pixel) begin
              state_next       = ST_LOAD;
              pixel_count_next = PIX_W'(1);
              frame_done_next  = 1'b0;
            end else begin
              err_seq_next = 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (fifo_wr_en) begin
            if (first_pixel) begin
              // A new pixel 0 mid-frame restarts the frame from one pixel.
              err_seq_next     = 1'b1;
              pixel_count_next = PIX_W'(1);
            end else begin
              pixel_count_next = pixel_inc;
              if (pixel_inc == PIX_LAST) begin
                state_next   = ST_COMPUTE;
                tmo_cnt_next = '0;
              end
            end
          end
          if (done_rise) begin
            err_seq_next = 1'b1;
          end
        end

        ST_COMPUTE: begin
          if (fifo_wr_en) begin
            err_seq_next = 1'b1;
          end
          // A completion in the same cycle as the timeout counts as a
          // clean finish, so check done_rise first.
          if (done_rise) begin
            state_next       = ST_DONE;
            frame_done_next  = 1'b1;
            frame_count_next = frame_count_reg + FRAME_CNT_WIDTH'(1);
          end else if (tmo_cnt_reg == TMO_LAST) begin
            state_next      = ST_DONE;
            frame_done_next = 1'b1;
            err_tmo_next    = 1'b1;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
          end
        end

        default: begin
          state_next = ST_RESET;
        end
      endcase
    end

    int_rst_n_next = (state_next != ST_RESET);
    busy_next      = (state_next == ST_LOAD) || (state_next == ST_COMPUTE);
  end

  assign internal_rst_n  = int_rst_n_reg;
  assign busy            = busy_reg;
  assign frame_done      = frame_done_reg;
  assign frame_count     = frame_count_reg;
  assign pixel_count     = pixel_count_reg;
  assign err_sequence    = err_seq_reg;
  assign err_weight_busy = err_wb_reg;
  assign err_timeout     = err_tmo_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
//
// Directed scenarios followed by a randomized stretch. Every cycle's outputs
// are compared against a frame-lifecycle reference model. The model tracks
// remaining reset cycles, separate loading/computing/done flags and compute
// age. Key boundary points also get checks against fixed values.
// -----------------------------------------------------------------------------
module tb_frame_sequencer;

  localparam int NP  = 8;
  localparam int RC  = 3;
  localparam int TO  = 20;
  localparam int FCW = 16;
  localparam int PW  = $clog2(NP + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           soft_reset_req = 1'b0;
  logic           first_pixel = 1'b0;
  logic           fifo_wr_en = 1'b0;
  logic           weight_we = 1'b0;
  logic           done_in = 1'b0;
  logic           internal_rst_n;
  logic           busy;
  logic           frame_done;
  logic [FCW-1:0] frame_count;
  logic [PW-1:0]  pixel_count;
  logic           err_sequence;
  logic           err_weight_busy;
  logic           err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_rst_left;
  bit m_loading, m_computing, m_done;
  int m_age;
  int m_fcount, m_pcount;
  bit m_eseq, m_ewb, m_eto;
  bit m_di_prev;

  frame_sequencer #(
    .NUM_PIXELS      (NP),
    .RESET_CYCLES    (RC),
    .TIMEOUT_CYCLES  (TO),
    .FRAME_CNT_WIDTH (FCW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .soft_reset_req  (soft_reset_req),
    .first_pixel     (first_pixel),
    .fifo_wr_en      (fifo_wr_en),
    .weight_we       (weight_we),
    .done_in         (done_in),
    .internal_rst_n  (internal_rst_n),
    .busy            (busy),
    .frame_done      (frame_done),
    .frame_count     (frame_count),
    .pixel_count     (pixel_count),
    .err_sequence    (err_sequence),
    .err_weight_busy (err_weight_busy),
    .err_timeout     (err_timeout)
  );

  always #5 clk = ~clk;

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    bit rise;
    rise = done_in && !m_di_prev;
    if (!rst_n) begin
      m_rst_left = RC; m_loading = 0; m_computing = 0; m_done = 0;
      m_age = 0; m_fcount = 0; m_pcount = 0;
      m_eseq = 0; m_ewb = 0; m_eto = 0; m_di_prev = 0;
      return;
    end
    m_di_prev = done_in;
    if (m_rst_left > 0) begin
      m_rst_left--;
      return;
    end
    if (soft_reset_req) begin
      m_rst_left = RC; m_loading = 0; m_computing = 0; m_done = 0;
      m_age = 0; m_pcount = 0; m_eseq = 0; m_ewb = 0; m_eto = 0;
      return;
    end
    if (weight_we && (m_loading || m_computing)) m_ewb = 1;
    if (m_loading) begin
      if (fifo_wr_en) begin
        if (first_pixel) begin
          m_eseq = 1; m_pcount = 1;
        end else begin
          m_pcount++;
          if (m_pcount == NP) begin
            m_loading = 0; m_computing = 1; m_age = 0;
          end
        end
      end
      if (rise) m_eseq = 1;
    end else if (m_computing) begin
      if (fifo_wr_en) m_eseq = 1;
      m_age++;
      if (rise) begin
        m_computing = 0; m_done = 1; m_fcount = (m_fcount + 1) % (1 << FCW);
      end else if (m_age == TO) begin
        m_computing = 0; m_done = 1; m_eto = 1;
      end
    end else begin
      if (fifo_wr_en) begin
        if (first_pixel) begin
          m_loading = 1; m_pcount = 1; m_done = 0;
        end else begin
          m_eseq = 1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("irst_n",  32'(internal_rst_n), 32'(m_rst_left == 0));
    check("busy",    32'(busy),           32'(m_loading || m_computing));
    check("fdone",   32'(frame_done),     32'(m_done));
    check("fcount",  32'(frame_count),    32'(m_fcount));
    check("pcount",  32'(pixel_count),    32'(m_pcount));
    check("eseq",    32'(err_sequence),   32'(m_eseq));
    check("ewb",     32'(err_weight_busy),32'(m_ewb));
    check("eto",     32'(err_timeout),    32'(m_eto));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_pixel(input bit first);
    fifo_wr_en = 1; first_pixel = first;
    tick();
    fifo_wr_en = 0; first_pixel = 0;
  endtask

  // n pixels with random 0..2 cycle gaps between writes, none after the last.
  task automatic send_pixels(input int n, input bit with_first);
    for (int i = 0; i < n; i++) begin
      write_pixel(with_first && (i == 0));
      if (i < n - 1) idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic soft_reset();
    soft_reset_req = 1;
    tick();
    soft_reset_req = 0;
    idle(RC);
  endtask

  initial begin
    // Step 1: power-on reset
    rst_n = 0;
    idle(2);
    check("t1_irst_in_reset", 32'(internal_rst_n), 32'd0);
    rst_n = 1;
    tick(); check("t1_irst_low1", 32'(internal_rst_n), 32'd0);
    tick(); check("t1_irst_low2", 32'(internal_rst_n), 32'd0);
    tick(); check("t1_irst_high", 32'(internal_rst_n), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_fcount", 32'(frame_count), 32'd0);
    $display("step 1: power-on reset released, n_cmp=%0d", n_cmp);

    // Step 2: normal frame
    write_pixel(1);
    check("t2_busy_after_first", 32'(busy), 32'd1);
    send_pixels(NP - 1, 0);
    check("t2_pcount_full", 32'(pixel_count), 32'(NP));
    idle(5);
    done_in = 1;
    tick();
    check("t2_fdone", 32'(frame_done), 32'd1);
    check("t2_fcount", 32'(frame_count), 32'd1);
    check("t2_busy_low", 32'(busy), 32'd0);
    done_in = 0;
    idle(2);
    $display("step 2: normal frame complete, frame_count=%0d", frame_count);

    // Step 3: compute timeout, then a clean frame
    send_pixels(NP, 1);
    idle(TO - 1);
    check("t3_not_yet_done", 32'(frame_done), 32'd0);
    tick();
    check("t3_timeout_done", 32'(frame_done), 32'd1);
    check("t3_err_timeout", 32'(err_timeout), 32'd1);
    check("t3_fcount_kept", 32'(frame_count), 32'd1);
    send_pixels(NP, 1);
    idle(3);
    done_in = 1; tick(); done_in = 0;
    check("t3_second_frame", 32'(frame_count), 32'd2);
    idle(1);
    $display("step 3: timeout frame and recovery frame done");

    // Step 4: soft reset mid-load with simultaneous writes
    send_pixels(4, 1);
    check("t4_pcount4", 32'(pixel_count), 32'd4);
    soft_reset_req = 1; fifo_wr_en = 1; weight_we = 1;
    tick();
    soft_reset_req = 0; fifo_wr_en = 0; weight_we = 0;
    check("t4_pcount_clr", 32'(pixel_count), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_fcount_kept", 32'(frame_count), 32'd2);
    check("t4_ewb_ignored", 32'(err_weight_busy), 32'd0);
    check("t4_eto_cleared", 32'(err_timeout), 32'd0);
    tick(); check("t4_irst_low", 32'(internal_rst_n), 32'd0);
    tick(); check("t4_irst_low2", 32'(internal_rst_n), 32'd0);
    tick(); check("t4_irst_high", 32'(internal_rst_n), 32'd1);
    $display("step 4: soft reset mid-load handled");

    // Step 5: protocol errors
    write_pixel(1);
    weight_we = 1; tick(); weight_we = 0;
    check("t5_ewb", 32'(err_weight_busy), 32'd1);
    send_pixels(NP - 1, 0);
    check("t5_eseq_clean", 32'(err_sequence), 32'd0);
    write_pixel(0);
    check("t5_overrun", 32'(err_sequence), 32'd1);
    idle(4);
    check("t5_ewb_held", 32'(err_weight_busy), 32'd1);
    soft_reset();
    write_pixel(0);
    check("t5_idle_stray", 32'(err_sequence), 32'd1);
    check("t5_stray_nocount", 32'(pixel_count), 32'd0);
    soft_reset();
    check("t5_eseq_cleared", 32'(err_sequence), 32'd0);
    $display("step 5: protocol errors flagged and cleared");

    // Step 6: done_in held high across frames
    send_pixels(NP, 1);
    done_in = 1; tick();
    check("t6_first_done", 32'(frame_done), 32'd1);
    send_pixels(NP, 1);
    idle(3);
    check("t6_no_spurious", 32'(frame_done), 32'd0);
    check("t6_still_busy", 32'(busy), 32'd1);
    done_in = 0; tick();
    done_in = 1; tick();
    check("t6_done_on_rise", 32'(frame_done), 32'd1);
    done_in = 0;
    idle(2);
    $display("step 6: level-held done_in handled, frame_count=%0d", frame_count);

    // Step 7: randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_n          = ($urandom_range(0, 299) != 0);
      soft_reset_req = ($urandom_range(0, 79) == 0);
      fifo_wr_en     = ($urandom_range(0, 2) != 0);
      first_pixel    = fifo_wr_en && ($urandom_range(0, 11) == 0);
      weight_we      = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) done_in = ~done_in;
      tick();
    end
    rst_n = 1; soft_reset_req = 0; fifo_wr_en = 0; first_pixel = 0;
    weight_we = 0; done_in = 0;
    idle(4);
    $display("step 7: random traffic complete, frame_count=%0d", frame_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Per-frame lifecycle controller for the lane-detection accelerator. Generates the multi-cycle soft-reset pulse for the datapath and tracks each frame through load, compute and done. Counts pixels accepted into the input FIFO, detects completion from post-process, and enforces a compute timeout. Exposes busy, done, frame count and sticky error flags to the AXI register read mux. Replaces the ad-hoc soft-reset counter and busy flag in the top level.

Parameters:
NUM_PIXELS, 131072, pixels per frame (IN_WIDTH*IN_HEIGHT).
RESET_CYCLES, 15, cycles internal_rst_n is held low per reset.
TIMEOUT_CYCLES, 16777216, maximum COMPUTE-state cycles before abort.
FRAME_CNT_WIDTH, 16, width of frame_count.

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
soft_reset_req  in  1  one-cycle pulse, decoded AXI write to the RESET register
first_pixel  in  1  qualifies fifo_wr_en as pixel 0 of a frame
fifo_wr_en  in  1  pixel accepted into input FIFO
weight_we  in  1  weight memory write
done_in  in  1  post-process o_valid level
internal_rst_n  out  1  registered active-low reset to datapath
busy  out  1  high in LOAD or COMPUTE
frame_done  out  1  sticky, high in DONE
frame_count  out  FRAME_CNT_WIDTH  completed frames, wraps
pixel_count  out  $clog2(NUM_PIXELS+1)  pixels accepted this frame
err_sequence  out  1  sticky protocol error
err_weight_busy  out  1  sticky: weight write while busy
err_timeout  out  1  sticky: compute timeout

Behaviour:
- All outputs registered; each reflects the triggering event one cycle later.
- States: RESET, IDLE, LOAD, COMPUTE, DONE.
- While rst_n is low at a clock edge: state=RESET, reset counter=0, internal_rst_n=0, busy=0, frame_done=0, frame_count=0, pixel_count=0, all err_*=0, done_in edge register=0, timeout counter=0.
- RESET: internal_rst_n=0, counter increments each cycle. When counter reaches RESET_CYCLES-1, go to IDLE; internal_rst_n=1 from the first IDLE cycle. Exactly RESET_CYCLES low cycles after rst_n deasserts.
- soft_reset_req in any state other than RESET: next state RESET, counter=0.
  - Clears pixel_count, frame_done, all err_*, and the timeout counter.
  - frame_count is preserved; only rst_n clears it.
  - soft_reset_req during RESET is ignored; the counter is not restarted.
  - soft_reset_req has priority over every simultaneous event.
- done_in rise = done_in & ~done_in_d. done_in_d is registered every cycle.
- IDLE/DONE:
  - fifo_wr_en&first_pixel: go to LOAD, pixel_count=1, frame_done=0.
  - fifo_wr_en without first_pixel: set err_sequence, stay, no count.
- LOAD:
  - fifo_wr_en&~first_pixel: pixel_count+1. If the write makes pixel_count==NUM_PIXELS, go to COMPUTE and clear the timeout counter.
  - fifo_wr_en&first_pixel: set err_sequence, pixel_count=1 (frame restarts).
  - done_in rise: set err_sequence, ignored.
- COMPUTE:
  - Timeout counter increments each cycle.
  - done_in rise: go to DONE, frame_done=1, frame_count+1 (modulo 2^FRAME_CNT_WIDTH).
  - If the counter reaches TIMEOUT_CYCLES-1 without done_in rise: set err_timeout, go to DONE, frame_done=1, frame_count unchanged.
  - done_in rise in the same cycle as timeout: treat as done; no error.
  - fifo_wr_en: set err_sequence (overrun). Exception: fifo_wr_en&first_pixel is accepted as a new frame only from DONE.
- weight_we while busy: set err_weight_busy. The write itself is not blocked.
- pixel_count holds its final value through COMPUTE/DONE until the next frame starts.
- busy=0 in RESET, IDLE and DONE.

Test Plan:
(Bench parameters: NUM_PIXELS=8, RESET_CYCLES=3, TIMEOUT_CYCLES=20.)
1. rst_n low 2 cycles then high → internal_rst_n low for exactly 3 cycles after release; IDLE; all outputs 0.
2. first_pixel+8 writes (gaps allowed), done_in high 5 cycles later → busy=1 from cycle after first write. COMPUTE after 8th write. frame_done=1, frame_count=1, busy=0 one cycle after done_in rise. pixel_count=8.
3. Full frame with done_in never asserted → err_timeout=1 and DONE exactly 20 cycles after entering COMPUTE; frame_count unchanged; a second frame then starts normally.
4. Mid-LOAD (pixel_count=4) soft_reset_req → internal_rst_n low 3 cycles; pixel_count=0; busy=0; frame_count preserved; simultaneous weight_we/fifo_wr_en ignored.
5. Protocol errors: fifo_wr_en without first_pixel in IDLE; a 9th write in COMPUTE; weight_we during LOAD → err_sequence=1, err_weight_busy=1, held until soft reset.
6. done_in held high from the previous frame into a new frame → no spurious completion (edge only); completes on the next rise.
